xor_eval_sequencer: RTL

Self-test stimulus and scoring stage placed directly upstream and downstream of the 2-3-2 XOR forward-propagation network. It drives `x_input`/`y_input` and a per-vector network reset. It waits out the floating-point pipeline latency, then samples the network's `predicted`/`expected` one-hot codes. It sweeps all four XOR vectors and reports a pass count and a per-vector result mask for on-board accuracy checking.

---
 rtl/xor_eval_pkg.sv | 28 ++
 rtl/xor_eval_sequencer_scoreboard.sv | 68 ++++++
 rtl/xor_eval_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/xor_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_eval_pkg
//  Description : Shared states, code constants and helpers for the XOR
//                network self-test sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_eval_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NN_RST = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam int NUM_VECTORS = 4;

   localparam logic [1:0] CODE_CLASS0 = 2'b01;
   localparam logic [1:0] CODE_CLASS1 = 2'b10;

   function automatic logic is_onehot2(input logic [1:0] code);
      return (code == CODE_CLASS0) || (code == CODE_CLASS1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/xor_eval_sequencer_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : xor_eval_scoreboard
//  Description : Scores one sampled network result per sample_en pulse and
//                accumulates pass count, per-vector mask and invalid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_eval_scoreboard
   import xor_eval_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       sample_en,
   input  logic [1:0] idx,
   input  logic [1:0] predicted,
   input  logic [1:0] expected,
   output logic [2:0] pass_count,
   output logic [3:0] result_mask,
   output logic       invalid_seen
);

   logic [2:0] pass_count_q, pass_count_d;
   logic [3:0] result_mask_q, result_mask_d;
   logic       invalid_seen_q, invalid_seen_d;
   logic       vec_pass;

   always_comb begin
      vec_pass       = (predicted == expected) && is_onehot2(predicted);
      pass_count_d   = pass_count_q;
      result_mask_d  = result_mask_q;
      invalid_seen_d = invalid_seen_q;
      if (clear) begin
         pass_count_d   = 3'd0;
         result_mask_d  = 4'd0;
         invalid_seen_d = 1'b0;
      end else if (sample_en) begin
         if (vec_pass) begin
            // Saturate so a stray extra sample can never wrap the count.
            if (pass_count_q != 3'(NUM_VECTORS)) begin
               pass_count_d = pass_count_q + 3'd1;
            end
            result_mask_d[idx] = 1'b1;
         end
         if (!is_onehot2(predicted)) begin
            invalid_seen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_count_q   <= 3'd0;
         result_mask_q  <= 4'd0;
         invalid_seen_q <= 1'b0;
      end else begin
         pass_count_q   <= pass_count_d;
         result_mask_q  <= result_mask_d;
         invalid_seen_q <= invalid_seen_d;
      end
   end

   assign pass_count   = pass_count_q;
   assign result_mask  = result_mask_q;
   assign invalid_seen = invalid_seen_q;

endmodule
`default_nettype wire

// File: rtl/xor_eval_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : xor_eval_sequencer
//  Description : Sweeps the four XOR vectors through the network, waits out
//                the pipeline latency and scores each result.
//                XOR_EVAL_LOOP_EN: continuous sweeps with run/fail counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_eval_sequencer
   import xor_eval_pkg::*;
#(
   parameter int SETTLE_CYCLES = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  predicted,
   input  logic [1:0]  expected,
   output logic        x_input,
   output logic        y_input,
   output logic        nn_reset,
   output logic        busy,
   output logic        done,
   output logic [2:0]  pass_count,
   output logic [3:0]  result_mask,
   output logic        invalid_seen
`ifdef XOR_EVAL_LOOP_EN
   ,
   output logic [15:0] run_count,
   output logic [15:0] fail_runs
`endif
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0]       IDX_LAST    = 2'(NUM_VECTORS - 1);

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic             sb_clear;
   logic             sb_sample;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      settle_cnt_d = settle_cnt_q;
      sb_clear     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d    = 2'd0;
               sb_clear = 1'b1;
               state_d  = NN_RST;
            end
         end
         NN_RST: begin
            settle_cnt_d = '0;
            state_d      = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = NN_RST;
            end
         end
         DONE: begin
`ifdef XOR_EVAL_LOOP_EN
            idx_d    = 2'd0;
            sb_clear = 1'b1;
            state_d  = NN_RST;
`else
            if (start) begin
               idx_d    = 2'd0;
               sb_clear = 1'b1;
               state_d  = NN_RST;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // idx only moves on the NN_RST entry edge, so x/y are stable per vector.
   assign busy      = (state_q == NN_RST) || (state_q == SETTLE) || (state_q == SAMPLE);
   assign nn_reset  = (state_q == NN_RST);
   assign done      = (state_q == DONE);
   assign x_input   = busy & idx_q[0];
   assign y_input   = busy & idx_q[1];
   assign sb_sample = (state_q == SAMPLE);

   xor_eval_scoreboard u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .clear        (sb_clear),
      .sample_en    (sb_sample),
      .idx          (idx_q),
      .predicted    (predicted),
      .expected     (expected),
      .pass_count   (pass_count),
      .result_mask  (result_mask),
      .invalid_seen (invalid_seen)
   );

`ifdef XOR_EVAL_LOOP_EN
   logic [15:0] run_count_q, run_count_d;
   logic [15:0] fail_runs_q, fail_runs_d;

   // DONE lasts one cycle in loop mode, so results are final exactly then.
   always_comb begin
      run_count_d = run_count_q;
      fail_runs_d = fail_runs_q;
      if (state_q == DONE) begin
         if (run_count_q != 16'hFFFF) begin
            run_count_d = run_count_q + 16'd1;
         end
         if ((pass_count != 3'(NUM_VECTORS)) && (fail_runs_q != 16'hFFFF)) begin
            fail_runs_d = fail_runs_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_count_q <= 16'd0;
         fail_runs_q <= 16'd0;
      end else begin
         run_count_q <= run_count_d;
         fail_runs_q <= fail_runs_d;
      end
   end

   assign run_count = run_count_q;
   assign fail_runs = fail_runs_q;
`endif

endmodule
`default_nettype wire
